i2c_master_byte_fsm: RTL

- Bit/byte-level I2C master controller, one stage upstream of the SCL clock generator.
- Drives that generator's clock enable and consumes its SCL output, edge-detected in the core clock domain.
- Performs one single-byte transaction per request: START, 7-bit address + R/W, ACK check, one data byte (write, or read with master NACK), STOP.
- Drives SDA with open-drain convention (0 = pull low, 1 = release).

---
 rtl/i2c_master_byte_fsm.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_byte_fsm.sv
// i2c_master_byte_fsm: single-byte I2C master bit/byte sequencer.
// Drives the SCL generator enable and open-drain SDA, one transfer per start.
module i2c_master_byte_fsm #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      i2c_core_clk_i,
  input  logic                      reset_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      start_i,
  input  logic [6:0]                slave_addr_i,
  input  logic                      rw_i,
  input  logic [7:0]                wr_data_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      clk_en_o,
  output logic                      sda_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      ack_err_o,
  output logic [7:0]                rd_data_o
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_NACK,
    S_STOP_LOW,
    S_STOP_WAIT,
    S_BUS_FREE
  } state_e;

  state_e                    state_q, state_d;
  logic                      scl_q;
  logic [7:0]                shift_q, shift_d;
  logic [7:0]                wdata_q, wdata_d;
  logic                      rw_q, rw_d;
  logic                      nack_q, nack_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      clk_en_q, clk_en_d;
  logic                      sda_q, sda_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      ack_err_q, ack_err_d;
  logic [7:0]                rd_data_q, rd_data_d;

  logic                      scl_fall;
  logic                      scl_rise;
  logic [PRESCALE_WIDTH-1:0] half_w;
  logic [PRESCALE_WIDTH-1:0] hold_w;

  assign scl_fall = scl_q & ~scl_i;
  assign scl_rise = ~scl_q & scl_i;
  assign half_w   = prescale_i >> 1;
  assign hold_w   = (half_w == '0) ? ONE : half_w;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    clk_en_d  = clk_en_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          shift_d   = {slave_addr_i, rw_i};
          wdata_d   = wr_data_i;
          rw_d      = rw_i;
          sda_d     = 1'b0;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          cnt_d     = hold_w;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cnt_q <= ONE) begin
          clk_en_d  = 1'b1;
          bit_cnt_d = 4'd0;
          state_d   = S_ADDR;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_ADDR, S_WR_DATA: begin
        if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_d   = 1'b1;
            state_d = (state_q == S_ADDR) ? S_ADDR_ACK
                                          : S_WR_ACK;
          end else begin
            sda_d     = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_ADDR_ACK: begin
        if (scl_rise) nack_d = sda_i;
        if (scl_fall) begin
          if (nack_q) begin
            ack_err_d = 1'b1;
            sda_d     = 1'b0;
            state_d   = S_STOP_LOW;
          end else if (rw_q) begin
            sda_d     = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = S_RD_DATA;
          end else begin
            // bit 7 goes out on this fall, so one bit is already sent
            sda_d     = wdata_q[7];
            shift_d   = {wdata_q[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            state_d   = S_WR_DATA;
          end
        end
      end
      S_WR_ACK: begin
        if (scl_rise) nack_d = sda_i;
        if (scl_fall) begin
          sda_d   = 1'b0;
          if (nack_q) ack_err_d = 1'b1;
          state_d = S_STOP_LOW;
        end
      end
      S_RD_DATA: begin
        sda_d = 1'b1;
        if (scl_rise && bit_cnt_q != 4'd8) begin
          shift_d   = {shift_q[6:0], sda_i};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (scl_fall && bit_cnt_q == 4'd8) begin
          state_d = S_RD_NACK;
        end
      end
      S_RD_NACK: begin
        if (scl_fall) begin
          sda_d   = 1'b0;
          state_d = S_STOP_LOW;
        end
      end
      S_STOP_LOW: begin
        if (scl_rise) begin
          clk_en_d = 1'b0;
          cnt_d    = hold_w;
          state_d  = S_STOP_WAIT;
        end
      end
      S_STOP_WAIT: begin
        if (cnt_q <= ONE) begin
          sda_d   = 1'b1;
          cnt_d   = hold_w;
          state_d = S_BUS_FREE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_BUS_FREE: begin
        if (cnt_q <= ONE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (rw_q && !ack_err_q) rd_data_d = shift_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      scl_q     <= 1'b1;
      shift_q   <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_en_q  <= 1'b0;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      scl_q     <= scl_i;
      shift_q   <= shift_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      clk_en_q  <= clk_en_d;
      sda_q     <= sda_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign clk_en_o  = clk_en_q;
  assign sda_o     = sda_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ack_err_o = ack_err_q;
  assign rd_data_o = rd_data_q;

endmodule
